// File: rtl/ascon_permutation.sv
// Iterative Ascon-p[rnd] permutation: 320-bit state register, UNROLL rounds per clock.
// Also holds the bitsliced 5-bit S-box layer that the round datapath instantiates.

module substitution_layer (
    input  logic [4:0][63:0] state_i,
    output logic [4:0][63:0] state_o
);

    logic [63:0] x0, x1, x2, x3, x4;
    logic [63:0] t0, t1, t2, t3, t4;

    // Bitsliced chi-like S-box; every bit column of the five words is one 5-bit S-box input.
    always_comb begin
        x0 = state_i[0] ^ state_i[4];
        x1 = state_i[1];
        x2 = state_i[2] ^ state_i[1];
        x3 = state_i[3];
        x4 = state_i[4] ^ state_i[3];
        t0 = ~x0 & x1;
        t1 = ~x1 & x2;
        t2 = ~x2 & x3;
        t3 = ~x3 & x4;
        t4 = ~x4 & x0;
        x0 = x0 ^ t1;
        x1 = x1 ^ t2;
        x2 = x2 ^ t3;
        x3 = x3 ^ t4;
        x4 = x4 ^ t0;
        x1 = x1 ^ x0;
        x0 = x0 ^ x4;
        x3 = x3 ^ x2;
        x2 = ~x2;
        state_o[0] = x0;
        state_o[1] = x1;
        state_o[2] = x2;
        state_o[3] = x3;
        state_o[4] = x4;
    end

endmodule

module ascon_permutation #(
    parameter int unsigned UNROLL = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [4:0]       rounds_i,
    input  logic [4:0][63:0] state_i,
    output logic [4:0][63:0] state_o,
    output logic             busy_o,
    output logic             done_o
);

    typedef enum logic {StIdle, StRun} fsm_e;

    fsm_e             fsm_q, fsm_d;
    logic [4:0][63:0] s_q;
    logic [4:0]       idx_q;
    logic [4:0]       rem_q;
    logic             done_q;

    logic [4:0]       rounds_clamp;
    logic [4:0]       step_n;
    logic             accept;
    logic             run_last;
    logic [4:0][63:0] stage [UNROLL+1];

    function automatic logic [63:0] ror64(input logic [63:0] x, input int unsigned n);
        return (x >> n) | (x << (64 - n));
    endfunction

    function automatic logic [4:0][63:0] linear_layer(input logic [4:0][63:0] s);
        logic [4:0][63:0] r;
        r[0] = s[0] ^ ror64(s[0], 19) ^ ror64(s[0], 28);
        r[1] = s[1] ^ ror64(s[1], 61) ^ ror64(s[1], 39);
        r[2] = s[2] ^ ror64(s[2], 1)  ^ ror64(s[2], 6);
        r[3] = s[3] ^ ror64(s[3], 10) ^ ror64(s[3], 17);
        r[4] = s[4] ^ ror64(s[4], 7)  ^ ror64(s[4], 41);
        return r;
    endfunction

    // Indexed over the 16-round schedule; p12 starts at index 4, p8 at index 8.
    function automatic logic [7:0] round_const(input logic [3:0] c);
        logic [7:0] k;
        case (c)
            4'h0: k = 8'h3c;
            4'h1: k = 8'h2d;
            4'h2: k = 8'h1e;
            4'h3: k = 8'h0f;
            4'h4: k = 8'hf0;
            4'h5: k = 8'he1;
            4'h6: k = 8'hd2;
            4'h7: k = 8'hc3;
            4'h8: k = 8'hb4;
            4'h9: k = 8'ha5;
            4'ha: k = 8'h96;
            4'hb: k = 8'h87;
            4'hc: k = 8'h78;
            4'hd: k = 8'h69;
            4'he: k = 8'h5a;
            4'hf: k = 8'h4b;
            default: k = 8'h00;
        endcase
        return k;
    endfunction

    always_comb begin
        rounds_clamp = (rounds_i > 5'd16) ? 5'd16 : rounds_i;
        accept       = (fsm_q == StIdle) && start_i;
        step_n       = (rem_q < 5'(UNROLL)) ? rem_q : 5'(UNROLL);
        run_last     = (fsm_q == StRun) && (rem_q == step_n);
    end

    assign stage[0] = s_q;

    // Stages at or beyond step_n pass their input through untouched.
    for (genvar k = 0; k < UNROLL; k++) begin : g_round
        logic [3:0]       cidx;
        logic [4:0][63:0] c_added;
        logic [4:0][63:0] s_out;

        always_comb begin
            cidx             = idx_q[3:0] + 4'(k);
            c_added          = stage[k];
            c_added[2][7:0]  = stage[k][2][7:0] ^ round_const(cidx);
        end

        substitution_layer u_sbox (
            .state_i (c_added),
            .state_o (s_out)
        );

        assign stage[k+1] = (5'(k) < step_n) ? linear_layer(s_out) : stage[k];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q <= StIdle;
        end else begin
            fsm_q <= fsm_d;
        end
    end

    always_comb begin
        fsm_d = fsm_q;
        case (fsm_q)
            StIdle:  if (accept && (rounds_clamp != 5'd0)) fsm_d = StRun;
            StRun:   if (run_last) fsm_d = StIdle;
            default: fsm_d = StIdle;
        endcase
    end

    always_comb begin
        busy_o  = (fsm_q == StRun);
        done_o  = done_q;
        state_o = s_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_q    <= '0;
            idx_q  <= '0;
            rem_q  <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                s_q    <= state_i;
                idx_q  <= 5'd16 - rounds_clamp;
                rem_q  <= rounds_clamp;
                done_q <= (rounds_clamp == 5'd0);
            end else if (fsm_q == StRun) begin
                s_q    <= stage[UNROLL];
                idx_q  <= idx_q + step_n;
                rem_q  <= rem_q - step_n;
                done_q <= run_last;
            end
        end
    end

endmodule
